// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: streaming XOR cipher with a repeating latched key.
// It supports plain XOR, chained encryption (ciphertext feedback seeded by
// an IV) and the matching chained decryption. The input and output each use
// a ready/valid handshake, and the result appears one cycle after an accept.
module xor_stream_cipher #(
  parameter int MSG_SIZE = 512,
  parameter int KEY_SIZE = 512,
  parameter int WORD_W   = 8
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iStart,
  input  logic [1:0]                          iMode,
  input  logic [KEY_SIZE-1:0]                 iKey,
  input  logic [WORD_W-1:0]                   iIv,
  input  logic [WORD_W-1:0]                   iMsg_word,
  input  logic                                iMsg_valid,
  output logic                                oMsg_ready,
  output logic [WORD_W-1:0]                   oOut_word,
  output logic                                oOut_valid,
  input  logic                                iOut_ready,
  output logic                                oBusy,
  output logic                                oDone,
  output logic [$clog2(MSG_SIZE/WORD_W):0]    oWord_count
);

  localparam int N   = MSG_SIZE / WORD_W;
  localparam int K   = KEY_SIZE / WORD_W;
  localparam int KIW = (K > 1) ? $clog2(K) : 1;
  localparam int CW  = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [KEY_SIZE-1:0] key_q;
  logic [1:0]          mode_q;
  logic [WORD_W-1:0]   chain_q;
  logic [WORD_W-1:0]   chain_next;
  logic [KIW-1:0]      key_idx;
  logic [CW-1:0]       count_q;
  logic [WORD_W-1:0]   out_word;
  logic                out_valid;
  logic [WORD_W-1:0]   key_word;
  logic [WORD_W-1:0]   result;
  logic                msg_ready;
  logic                accept;
  logic                last_word;
  logic                start_ok;

  assign msg_ready = (state == RUN) && (!out_valid || iOut_ready);
  assign accept    = iMsg_valid && msg_ready;
  assign last_word = (count_q == CW'(N - 1));
  assign key_word  = key_q[key_idx*WORD_W +: WORD_W];

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A restart from DONE waits until the last result has drained.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          state_next = RUN;
          start_ok   = 1'b1;
        end
      end
      RUN: begin
        if (accept && last_word) state_next = DONE;
      end
      DONE: begin
        if (iStart && !out_valid) begin
          state_next = RUN;
          start_ok   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Cipher datapath. Mode 11 falls through to plain XOR.
  always_comb begin
    result     = iMsg_word ^ key_word;
    chain_next = chain_q;
    case (mode_q)
      2'b01: begin
        result     = iMsg_word ^ key_word ^ chain_q;
        chain_next = iMsg_word ^ key_word ^ chain_q;
      end
      2'b10: begin
        result     = iMsg_word ^ key_word ^ chain_q;
        chain_next = iMsg_word;
      end
      default: ;
    endcase
  end

  // Latched parameters, counters, chain register and the output stage
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      key_q     <= '0;
      mode_q    <= '0;
      chain_q   <= '0;
      key_idx   <= '0;
      count_q   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        key_q   <= iKey;
        mode_q  <= iMode;
        chain_q <= iIv;
        key_idx <= '0;
        count_q <= '0;
      end else if (accept) begin
        chain_q <= chain_next;
        key_idx <= (key_idx == KIW'(K - 1)) ? '0 : key_idx + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (accept) begin
        out_word  <= result;
        out_valid <= 1'b1;
      end else if (iOut_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign oMsg_ready  = msg_ready;
  assign oOut_word   = out_word;
  assign oOut_valid  = out_valid;
  assign oBusy       = (state == RUN) || out_valid;
  assign oDone       = (state == DONE) && !out_valid;
  assign oWord_count = count_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed testbench for xor_stream_cipher. It uses a 32-bit message,
// a 16-bit key (0xA55A, which gives key words 0x5A and 0xA5) and 8-bit words.
module tb_xor_stream_cipher;

  logic       clk = 1'b0;
  logic       iRst, iStart, iMsg_valid, iOut_ready;
  logic [1:0] iMode;
  logic [15:0] iKey;
  logic [7:0] iIv, iMsg_word;
  logic       oMsg_ready, oOut_valid, oBusy, oDone;
  logic [7:0] oOut_word;
  logic [2:0] oWord_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_w [4];
  logic [7:0] got [4];
  int         got_cyc [4];
  int         acc0_cyc;
  int         ngot;
  logic [7:0] stall_word [3];
  logic       stall_rdy [3];
  int         nstall;

  always #5 clk = ~clk;

  xor_stream_cipher #(.MSG_SIZE(32), .KEY_SIZE(16), .WORD_W(8)) dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iMode(iMode), .iKey(iKey),
    .iIv(iIv), .iMsg_word(iMsg_word), .iMsg_valid(iMsg_valid),
    .oMsg_ready(oMsg_ready), .oOut_word(oOut_word), .oOut_valid(oOut_valid),
    .iOut_ready(iOut_ready), .oBusy(oBusy), .oDone(oDone),
    .oWord_count(oWord_count)
  );

  // Drives in_w[] as a message and captures results. The optional stall holds
  // iOut_ready low once the first result appears. The optional restart pulses
  // iStart with bogus settings while the message is running.
  task automatic stream_run(input logic [1:0] mode, input logic [7:0] iv,
                            input int stall, input bit restart);
    int idx;
    int stall_left;
    bit stalled;
    idx = 0; ngot = 0; nstall = 0; stall_left = 0; stalled = 0; acc0_cyc = -1;
    iMode = mode; iIv = iv; iKey = 16'hA55A; iStart = 1'b1;
    iMsg_valid = 1'b0; iOut_ready = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    for (int c = 0; c < 60 && ngot < 4; c++) begin
      if (restart && c == 1) begin
        iStart = 1'b1; iMode = 2'b10; iKey = 16'h0000; iIv = 8'hFF;
      end else begin
        iStart = 1'b0;
      end
      if (stall > 0 && !stalled && oOut_valid) begin
        stall_left = stall; stalled = 1;
      end
      iOut_ready = (stall_left == 0);
      iMsg_valid = (idx < 4);
      iMsg_word  = in_w[(idx < 4) ? idx : 0];
      #1;
      if (stall_left > 0) begin
        stall_word[nstall] = oOut_word;
        stall_rdy[nstall]  = oMsg_ready;
        nstall++;
        stall_left--;
      end
      if (oOut_valid && iOut_ready) begin
        got[ngot] = oOut_word; got_cyc[ngot] = c; ngot++;
      end
      if (iMsg_valid && oMsg_ready) begin
        if (idx == 0) acc0_cyc = c;
        idx++;
      end
      @(negedge clk);
    end
    iStart = 1'b0; iMsg_valid = 1'b0; iOut_ready = 1'b1;
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    in_w[0] = a; in_w[1] = b; in_w[2] = c; in_w[3] = d;
  endtask

  task automatic test_reset();
    iRst = 1'b0; iStart = 1'b0; iMode = 2'b00; iKey = '0; iIv = '0;
    iMsg_word = '0; iMsg_valid = 1'b0; iOut_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({oMsg_ready, oOut_valid, oBusy, oDone, oOut_word, oWord_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b val=%b busy=%b done=%b word=%h cnt=%0d required all 0",
               oMsg_ready, oOut_valid, oBusy, oDone, oOut_word, oWord_count);
    end
    iRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode00();
    logic [7:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hB4; exp[2] = 8'h78; exp[3] = 8'h96;
    set_inputs(8'h00, 8'h11, 8'h22, 8'h33);
    stream_run(2'b00, 8'h00, 0, 0);
    checks++;
    if (ngot !== 4) begin
      errors++; $display("FAIL m00_count_out: got %0d outputs required 4", ngot);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL m00_word%0d: got %h required %h", i, got[i], exp[i]);
      end
      checks++;
      if (got_cyc[i] !== acc0_cyc + 1 + i) begin
        errors++;
        $display("FAIL m00_timing%0d: got cycle %0d required %0d", i, got_cyc[i], acc0_cyc + 1 + i);
      end
    end
    checks++;
    if (oDone !== 1'b1 || oOut_valid !== 1'b0 || oBusy !== 1'b0 || oMsg_ready !== 1'b0) begin
      errors++;
      $display("FAIL m00_done: got done=%b val=%b busy=%b rdy=%b required 1 0 0 0",
               oDone, oOut_valid, oBusy, oMsg_ready);
    end
    checks++;
    if (oWord_count !== 3'd4) begin
      errors++; $display("FAIL m00_word_count: got %0d required 4", oWord_count);
    end
  endtask

  task automatic test_ignored_in_done();
    iMsg_valid = 1'b1; iMsg_word = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (oOut_valid !== 1'b0 || oWord_count !== 3'd4 || oDone !== 1'b1) begin
        errors++;
        $display("FAIL done_ignore%0d: got val=%b cnt=%0d done=%b required 0 4 1",
                 i, oOut_valid, oWord_count, oDone);
      end
    end
    iMsg_valid = 1'b0;
  endtask

  task automatic test_mode01_with_restart();
    logic [7:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hEE; exp[2] = 8'h96; exp[3] = 8'h00;
    set_inputs(8'h00, 8'h11, 8'h22, 8'h33);
    stream_run(2'b01, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ngot || got[i] !== exp[i]) begin
        errors++; $display("FAIL m01_word%0d: got %h (n=%0d) required %h", i, got[i], ngot, exp[i]);
      end
    end
    checks++;
    if (oWord_count !== 3'd4 || oDone !== 1'b1) begin
      errors++; $display("FAIL m01_end: got cnt=%0d done=%b required 4 1", oWord_count, oDone);
    end
  endtask

  task automatic test_mode10();
    logic [7:0] exp [4];
    exp[0] = 8'h00; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33;
    set_inputs(8'h5A, 8'hEE, 8'h96, 8'h00);
    stream_run(2'b10, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ngot || got[i] !== exp[i]) begin
        errors++; $display("FAIL m10_word%0d: got %h (n=%0d) required %h", i, got[i], ngot, exp[i]);
      end
    end
  endtask

  task automatic test_mode11();
    logic [7:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hB4; exp[2] = 8'h78; exp[3] = 8'h96;
    set_inputs(8'h00, 8'h11, 8'h22, 8'h33);
    stream_run(2'b11, 8'hC3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ngot || got[i] !== exp[i]) begin
        errors++; $display("FAIL m11_word%0d: got %h (n=%0d) required %h", i, got[i], ngot, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hB4; exp[2] = 8'h78; exp[3] = 8'h96;
    set_inputs(8'h00, 8'h11, 8'h22, 8'h33);
    stream_run(2'b00, 8'h00, 3, 0);
    checks++;
    if (nstall !== 3) begin
      errors++; $display("FAIL bp_stall_len: got %0d stall cycles required 3", nstall);
    end
    for (int i = 0; i < nstall && i < 3; i++) begin
      checks++;
      if (stall_word[i] !== 8'h5A || stall_rdy[i] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got word=%h rdy=%b required 5a 0", i, stall_word[i], stall_rdy[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ngot || got[i] !== exp[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h (n=%0d) required %h", i, got[i], ngot, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (oOut_valid !== 1'b0 || oDone !== 1'b1 || oWord_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_no_extra: got val=%b done=%b cnt=%0d required 0 1 4", oOut_valid, oDone, oWord_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    exp[0] = 8'h5A; exp[1] = 8'hB4; exp[2] = 8'h78; exp[3] = 8'h96;
    iMode = 2'b01; iIv = 8'h3C; iKey = 16'hA55A; iStart = 1'b1; iOut_ready = 1'b1;
    @(negedge clk);
    iStart = 1'b0; iMsg_valid = 1'b1; iMsg_word = 8'h00;
    @(negedge clk);
    iMsg_word = 8'h11;
    @(negedge clk);
    iMsg_valid = 1'b0;
    checks++;
    if (oWord_count !== 3'd2) begin
      errors++; $display("FAIL mid_count: got %0d required 2", oWord_count);
    end
    iRst = 1'b0;
    @(negedge clk);
    checks++;
    if ({oMsg_ready, oOut_valid, oBusy, oDone, oOut_word, oWord_count} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%b val=%b busy=%b done=%b word=%h cnt=%0d required all 0",
               oMsg_ready, oOut_valid, oBusy, oDone, oOut_word, oWord_count);
    end
    iRst = 1'b1;
    @(negedge clk);
    set_inputs(8'h00, 8'h11, 8'h22, 8'h33);
    stream_run(2'b00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ngot || got[i] !== exp[i]) begin
        errors++; $display("FAIL mid_rerun_word%0d: got %h (n=%0d) required %h", i, got[i], ngot, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_ignored_in_done();
    test_mode01_with_restart();
    test_mode10();
    test_mode11();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Streaming, parametrised successor to the block-wide XOR encryptor.
- Processes a message of MSG_SIZE bits as a stream of WORD_W-bit words, under ready/valid handshakes on both input and output.
- Uses a latched KEY_SIZE-bit key that repeats when shorter than the message.
- Adds a chaining mode (ciphertext feedback with IV) and its matching decrypt mode; sits between the message assembler and the ciphertext serialiser.

Parameters:
- MSG_SIZE, 512: message length in bits; must be a multiple of WORD_W.
- KEY_SIZE, 512: key length in bits; must be a multiple of WORD_W and ≤ MSG_SIZE.
- WORD_W, 8: stream word width in bits.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  synchronous active-low reset.
- iStart  input  1  start pulse; latches iKey, iIv and iMode.
- iMode  input  2  00 = plain XOR, 01 = chain encrypt, 10 = chain decrypt, 11 = treated as 00.
- iKey  input  KEY_SIZE  key; word j = bits [j*WORD_W +: WORD_W].
- iIv  input  WORD_W  chaining initial value.
- iMsg_word  input  WORD_W  input data word.
- iMsg_valid  input  1  input word valid.
- oMsg_ready  output  1  block can accept an input word.
- oOut_word  output  WORD_W  result word.
- oOut_valid  output  1  result word valid.
- iOut_ready  input  1  downstream accepts result.
- oBusy  output  1  high in RUN, or while a result is pending.
- oDone  output  1  message complete and drained; held until the next iStart.
- oWord_count  output  $clog2(MSG_SIZE/WORD_W)+1  number of words accepted this message.

Behaviour:
- Reset: one clock, synchronous active-low reset (iRst low at a rising edge of iClk). State = IDLE; every output is 0, including oOut_word and oWord_count; key, IV, mode and chain registers are cleared.
- Reset mid-message aborts the message; no partial oDone.
- Definitions: N = MSG_SIZE/WORD_W, K = KEY_SIZE/WORD_W.
- States: IDLE, RUN, DONE.
- IDLE or DONE + iStart: latch iKey, iMode and chain register ← iIv; word count ← 0; key index ← 0; oDone ← 0; go to RUN.
- iStart in RUN is ignored.
- Accept: in RUN, oMsg_ready = !oOut_valid || iOut_ready. A word is accepted when iMsg_valid && oMsg_ready.
- Datapath on accept (k = key word at key index; m = input word):
  - Mode 00: out = m ^ k.
  - Mode 01: out = m ^ k ^ chain; chain ← out.
  - Mode 10: out = m ^ k ^ chain; chain ← m (the received ciphertext).
- Output register: out is loaded into oOut_word and oOut_valid is set 1 cycle after accept (latency 1).
- oOut_valid clears when iOut_ready is high and no new accept occurs in that cycle. Accept and drain in the same cycle leave oOut_valid at 1 with the new word, so full throughput is 1 word/cycle.
- oOut_word is stable while oOut_valid && !iOut_ready.
- Key index increments on each accept and wraps from K-1 to 0.
- oWord_count increments on each accept. When the N-th word is accepted, go to DONE and oMsg_ready drops to 0 the following cycle.
- oDone = 1 in DONE once oOut_valid = 0 (last word drained). It stays 1 until iStart or reset.
- Once in DONE, further iMsg_valid is ignored.
- oBusy = (state == RUN) || oOut_valid.
- iStart in DONE with the last word still undrained is ignored until drained.

Test Plan (WORD_W = 8, MSG_SIZE = 32, KEY_SIZE = 16, iKey = 0xA55A → key words 0x5A, 0xA5):
- Mode 00, input 0x00, 0x11, 0x22, 0x33 back-to-back, iOut_ready = 1 → outputs 0x5A, 0xB4, 0x78, 0x96 on consecutive cycles, 1-cycle latency; oDone = 1 the cycle after the last output; oWord_count = 4.
- Mode 01, iIv = 0x00, same input → outputs 0x5A, 0xEE, 0x96, 0x00.
- Mode 10, iIv = 0x00, input 0x5A, 0xEE, 0x96, 0x00 → outputs 0x00, 0x11, 0x22, 0x33 (round-trip).
- Backpressure: mode 00, iOut_ready low for 3 cycles after the first output → oOut_word holds 0x5A, oMsg_ready = 0, no word lost or duplicated; sequence completes unchanged.
- Reset mid-message: iRst low after 2 accepted words → next cycle all outputs 0, state IDLE; a new iStart with the same stimulus yields full correct output from word 0.
- iStart during RUN and iMsg_valid during DONE → both ignored; key/mode unchanged, oWord_count stays 4, no extra output.
